// File: rtl/popcount_sequencer_if.sv
// Word-in / count-out handshake bundle for popcount_sequencer.
// slave = sequencer side, master = producer/consumer side.
interface popcount_sequencer_if #(
   parameter int NIBBLES = 4,
   parameter int CNT_W   = 5
);
   logic                   in_valid;
   logic                   in_ready;
   logic [4*NIBBLES-1:0]   in_word;
   logic                   out_valid;
   logic                   out_ready;
   logic [CNT_W-1:0]       out_count;
   logic                   out_err;

   modport master (
      output in_valid, in_word, out_ready,
      input  in_ready, out_valid, out_count, out_err
   );

   modport slave (
      input  in_valid, in_word, out_ready,
      output in_ready, out_valid, out_count, out_err
   );
endinterface

// File: rtl/popcount_sequencer.sv
// Walks a word one nibble per cycle through an external one-hot ones-counter.
// Define POPSEQ_ONEHOT_CHECK_EN to flag and zero illegal datapath results.
module popcount_sequencer #(
   parameter int NIBBLES = 4,
   parameter int CNT_W   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   popcount_sequencer_if.slave  bus,
   output logic                 busy,
   output logic [3:0]           pc_nib,
   input  logic [4:0]           pc_onehot
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [W-1:0]      word;
   logic [W-1:0]      word_sh;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  acc;
   logic [CNT_W-1:0]  acc_nx;
   logic [2:0]        dec;

   // Word shifts right each RUN cycle and is fully drained by DONE,
   // so its low nibble is the datapath operand and reads 0 outside RUN.
   assign word_sh = word >> 4;
   assign pc_nib  = word[3:0];
   assign acc_nx  = acc + CNT_W'(dec);

`ifdef POPSEQ_ONEHOT_CHECK_EN
   logic bad;
   logic err;
   logic err_nx;

   always_comb begin
      dec = 3'd0;
      bad = 1'b0;
      case (pc_onehot)
         5'b00001: dec = 3'd0;
         5'b00010: dec = 3'd1;
         5'b00100: dec = 3'd2;
         5'b01000: dec = 3'd3;
         5'b10000: dec = 3'd4;
         default:  bad = 1'b1;
      endcase
   end

   assign err_nx = err | bad;
`else
   always_comb begin
      dec = 3'd0;
      priority casez (pc_onehot)
         5'b1????: dec = 3'd4;
         5'b01???: dec = 3'd3;
         5'b001??: dec = 3'd2;
         5'b0001?: dec = 3'd1;
         default:  dec = 3'd0;
      endcase
   end

   assign bus.out_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         word          <= '0;
         idx           <= '0;
         acc           <= '0;
         busy          <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_count <= '0;
`ifdef POPSEQ_ONEHOT_CHECK_EN
         err           <= 1'b0;
         bus.out_err   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  word         <= bus.in_word;
                  acc          <= '0;
                  idx          <= '0;
                  state        <= RUN;
                  busy         <= 1'b1;
                  bus.in_ready <= 1'b0;
`ifdef POPSEQ_ONEHOT_CHECK_EN
                  err          <= 1'b0;
`endif
               end
            end
            RUN: begin
               word <= word_sh;
               acc  <= acc_nx;
`ifdef POPSEQ_ONEHOT_CHECK_EN
               err  <= err_nx;
`endif
               if (idx == LAST) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.out_count <= acc_nx;
`ifdef POPSEQ_ONEHOT_CHECK_EN
                  bus.out_err   <= err_nx;
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  idx           <= '0;
                  busy          <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  bus.out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
